// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register serializer family.
// State encoding is common so left and right variants decode identically.
package shift_pkg;

   typedef logic state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

endpackage : shift_pkg

// File: rtl/left_shift_serializer.sv
// Parallel-in, serial-out MSB-first serializer with valid/ready on both sides.
// A load on the final beat replaces the shift so consecutive words stream without bubbles.
module left_shift_serializer
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             sin,
   input  logic             sout_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             last,
   output logic [WIDTH-1:0] dout
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dout;

   state_t           w_state_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] w_dout_nxt;

   logic             w_shift;
   logic             w_last_beat;
   logic             w_accept_in;

   assign w_shift     = (r_state == ST_SHIFT);
   assign w_last_beat = w_shift && (r_cnt == LAST_CNT);
   // Reset gating lives in the output decode; acceptance here ignores rst
   // because the clocked process lets rst override any update.
   assign w_accept_in = din_valid && (!w_shift || (w_last_beat && sout_ready));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_dout  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dout  <= w_dout_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      if (w_accept_in) begin
         w_state_nxt = ST_SHIFT;
         w_cnt_nxt   = '0;
         w_dout_nxt  = din;
      end else if (w_shift && sout_ready) begin
         w_dout_nxt = {r_dout[WIDTH-2:0], sin};
         if (w_last_beat) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      din_ready  = !rst && (!w_shift || (w_last_beat && sout_ready));
      sout_valid = !rst && w_shift;
      last       = !rst && w_last_beat;
      sout       = !rst && r_dout[WIDTH-1];
      dout       = r_dout;
   end

endmodule : left_shift_serializer
